movx_bus_ctrl: RTL
==================

Name: movx_bus_ctrl

Overview:
- External data-memory bus controller that executes MOVX cycles for the 8051 core.
- It is the consumer side of the data pointer. It reads the DPTR high/low bytes (or Ri with P2 as the high byte), then runs a multiplexed-style external read or write cycle with ALE, active-low strobes, programmable wait states and a ready handshake.
- It returns read data to the core's accumulator path.
- It sits between the core's execute unit and the external XDATA pins.

Parameters:
- WAIT_STATES, 1: minimum strobe-low cycles minus one. Legal range is 0..15.
- TIMEOUT, 255: maximum cycles the block waits on ext_ready low before aborting. Legal range is 1..65535.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a MOVX cycle. Sampled only in IDLE.
- rd_nwr  in  1  1 = read (MOVX A,@..), 0 = write (MOVX @..,A).
- use_dptr  in  1  1 = address is {dptr_h,dptr_l}; 0 = address is {p2,ri}.
- dptr_h  in  8  DPTR high byte.
- dptr_l  in  8  DPTR low byte.
- ri  in  8  R0/R1 value.
- p2  in  8  P2 SFR value.
- wr_data  in  8  accumulator value to write.
- busy  out  1  cycle in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse, coincident with done.
- rd_data  out  8  last successfully read byte.
- ext_addr  out  16  external address.
- ext_ale  out  1  address latch enable, active high.
- ext_rd_n  out  1  read strobe, active low.
- ext_wr_n  out  1  write strobe, active low.
- ext_data_out  out  8  write data.
- ext_data_oe  out  1  write data output enable.
- ext_data_in  in  8  read data from bus.
- ext_ready  in  1  external ready. Low inserts wait cycles.

Behaviour:
- Reset, asynchronous and effective immediately, also mid-cycle: state=IDLE, busy=0, done=0, err=0, rd_data=8'h00, ext_addr=16'h0000, ext_ale=0, ext_rd_n=1, ext_wr_n=1, ext_data_out=8'h00, ext_data_oe=0, counters=0. No partial strobe survives reset.
- All outputs are registered.
- FSM states: IDLE, ADDR, STROBE, HOLD.
- IDLE:
  - If start=1 at a clock edge, latch the address, rd_nwr and wr_data, then go to ADDR.
  - The address is {dptr_h,dptr_l} if use_dptr=1, else {p2,ri}.
  - Later changes to the inputs do not affect the cycle in flight.
- ADDR (exactly 1 cycle):
  - busy=1, ext_ale=1, ext_addr=latched address.
  - For a write, ext_data_out=latched data.
  - Wait counter loads WAIT_STATES. Timeout counter loads 0.
  - Next state: STROBE.
- STROBE:
  - ext_ale=0.
  - Read: ext_rd_n=0. Write: ext_wr_n=0 and ext_data_oe=1.
  - Counter decrements each cycle while non-zero.
  - When counter=0 and ext_ready=1 at the edge, a read captures ext_data_in into rd_data, and the state goes to HOLD.
  - When counter=0 and ext_ready=0, the state stays in STROBE and the timeout counter increments.
  - When the timeout counter reaches TIMEOUT, the cycle aborts: go to HOLD with the error flag set; rd_data is unchanged.
  - ext_ready is ignored while counter>0.
- HOLD (exactly 1 cycle):
  - Strobes are high.
  - ext_addr is held. ext_data_oe stays 1 for a write, for hold time.
  - done=1. err=1 only on timeout.
  - busy=1. Next state: IDLE.
- On returning to IDLE: busy=0, ext_data_oe=0. ext_addr holds its last value.
- Nominal latency: start sampled at edge E0. ALE is high in the cycle after E0. Strobe is low for WAIT_STATES+1 cycles plus any ready extension. done is high in the following cycle.
  - With WAIT_STATES=1 and ready=1, done is visible 4 cycles after E0.
  - Back-to-back starts give a throughput of one MOVX per WAIT_STATES+4 cycles.
- start while busy=1 is ignored; it is not queued. start asserted during the HOLD cycle is also ignored.
- ext_rd_n and ext_wr_n are never low simultaneously. ext_data_oe is never 1 during a read.
- Address wrap-around is not applicable; the address is a straight 16-bit pass-through, so 16'hFFFF is legal.

Test Plan:
- Reset mid-STROBE of a read (WAIT_STATES=1) -> all outputs at reset values in the same cycle, including ext_rd_n=1 and busy=0; rd_data=00.
- use_dptr=1, dptr_h=8'h12, dptr_l=8'h34, rd_nwr=1, ext_ready=1, ext_data_in=8'hA5 -> ALE=1 with ext_addr=16'h1234 at E0+1; rd_n low for 2 cycles; done at E0+4; rd_data=A5; ext_data_oe stays 0 throughout.
- use_dptr=0, p2=8'hFF, ri=8'h80, wr_data=8'h3C, rd_nwr=0 -> ext_addr=FF80; wr_n low 2 cycles; oe=1 from STROBE through HOLD; ext_data_out=3C; rd_data unchanged.
- Read with ext_ready held low for 3 cycles after wait states expire -> strobe low for 5 cycles; data captured on the first ready=1 edge; done at E0+7; err=0.
- TIMEOUT overridden to 4, ext_ready stuck low -> abort after 4 extension cycles; done=1 and err=1 for one cycle; rd_data keeps its previous value; strobes high.
- start pulsed during busy, and dptr_l changed during STROBE -> second request ignored (only one done pulse); ext_addr keeps the originally latched value.

Source files
------------

// File: rtl/movx_bus_ctrl.sv
// movx_bus_ctrl: external data-memory (XDATA) bus controller for 8051 MOVX.
// Latches the address (DPTR or P2:Ri), then runs ALE -> strobe -> hold with
// programmable wait states, ready-extension and a timeout abort.
// Every output is registered: output values are computed from the next state
// and loaded on the same edge as the state register.
module movx_bus_ctrl #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        rd_nwr,
    input  logic        use_dptr,
    input  logic [7:0]  dptr_h,
    input  logic [7:0]  dptr_l,
    input  logic [7:0]  ri,
    input  logic [7:0]  p2,
    input  logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rd_data,
    output logic [15:0] ext_addr,
    output logic        ext_ale,
    output logic        ext_rd_n,
    output logic        ext_wr_n,
    output logic [7:0]  ext_data_out,
    output logic        ext_data_oe,
    input  logic [7:0]  ext_data_in,
    input  logic        ext_ready
);

    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [15:0] TMO_MAX   = 16'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STROBE, S_HOLD} state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic [15:0] tmo_cnt;
    logic        rd_q;
    logic        abort;
    logic        capture;

    logic busy_d, done_d, err_d, ale_d, rd_n_d, wr_n_d, oe_d;

    // A read completes on the first ready edge once the wait states are spent
    assign capture = (state == S_STROBE) && (wait_cnt == 4'd0) && ext_ready && rd_q;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; abort flags a timeout exit from STROBE
    always_comb begin
        state_next = state;
        abort      = 1'b0;
        case (state)
            S_IDLE:   if (start) state_next = S_ADDR;
            S_ADDR:   state_next = S_STROBE;
            S_STROBE: begin
                if (wait_cnt == 4'd0) begin
                    if (ext_ready) begin
                        state_next = S_HOLD;
                    end else if (tmo_cnt == TMO_MAX) begin
                        state_next = S_HOLD;
                        abort      = 1'b1;
                    end
                end
            end
            S_HOLD:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Next output values, decoded from the state being entered
    always_comb begin
        busy_d = (state_next != S_IDLE);
        ale_d  = (state_next == S_ADDR);
        rd_n_d = !((state_next == S_STROBE) && rd_q);
        wr_n_d = !((state_next == S_STROBE) && !rd_q);
        oe_d   = !rd_q && ((state_next == S_STROBE) || (state_next == S_HOLD));
        done_d = (state_next == S_HOLD);
        err_d  = abort;
    end

    // Registered bus/handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ext_ale     <= 1'b0;
            ext_rd_n    <= 1'b1;
            ext_wr_n    <= 1'b1;
            ext_data_oe <= 1'b0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            ext_ale     <= ale_d;
            ext_rd_n    <= rd_n_d;
            ext_wr_n    <= wr_n_d;
            ext_data_oe <= oe_d;
        end
    end

    // Request latch: address, direction and write data frozen at acceptance
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext_addr     <= 16'h0000;
            ext_data_out <= 8'h00;
            rd_q         <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            ext_addr <= use_dptr ? {dptr_h, dptr_l} : {p2, ri};
            rd_q     <= rd_nwr;
            if (!rd_nwr) ext_data_out <= wr_data;
        end
    end

    // Read data capture; left untouched on writes and on timeout
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        rd_data <= 8'h00;
        else if (capture) rd_data <= ext_data_in;
    end

    // Wait-state and ready-timeout counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
            tmo_cnt  <= 16'd0;
        end else if (state == S_ADDR) begin
            wait_cnt <= WAIT_INIT;
            tmo_cnt  <= 16'd0;
        end else if (state == S_STROBE) begin
            if (wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            else if (!ext_ready && (tmo_cnt != TMO_MAX))
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

endmodule
